// File: rtl/calc1_pkg.sv
// Shared command/response encodings and the response-prediction entry for the calc1 port checker.
// Bit 0 is the MSB on every [0:n] field, matching the calc1 request/response buses.
package calc1_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_LSH = 4'd5;
  localparam logic [3:0] CMD_RSH = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_OVF  = 2'd2;
  localparam logic [1:0] RESP_INV  = 2'd3;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RESP  = 2'd1;
  localparam logic [1:0] ERR_DATA  = 2'd2;
  localparam logic [1:0] ERR_UNEXP = 2'd3;

  typedef struct packed {
    logic [0:1]  resp;
    logic [0:31] data;
  } pred_t;

  // 33-bit intermediate: w[0] is the carry/borrow out of the 32-bit result.
  function automatic pred_t predict(input logic [0:3] cmd, input logic [0:31] op1,
                                    input logic [0:31] op2);
    logic [0:32] w;
    pred_t       p;
    w      = '0;
    p.resp = RESP_INV;
    p.data = '0;
    case (cmd)
      CMD_ADD: begin
        w      = {1'b0, op1} + {1'b0, op2};
        p.resp = w[0] ? RESP_OVF : RESP_OK;
        p.data = w[1:32];
      end
      CMD_SUB: begin
        w      = {1'b0, op1} - {1'b0, op2};
        p.resp = (op1 < op2) ? RESP_OVF : RESP_OK;
        p.data = w[1:32];
      end
      CMD_LSH: begin
        p.resp = RESP_OK;
        p.data = op1 << op2[27:31];
      end
      CMD_RSH: begin
        p.resp = RESP_OK;
        p.data = op1 >> op2[27:31];
      end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/calc1_chk_fifo.sv
// Expected-response queue: DEPTH x W, push visible one cycle later, head read combinationally.
// Same-cycle push/pop allowed; a push while full is dropped unless a pop frees the slot that cycle.
module calc1_chk_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign rd_en    = pop_rdy && !empty;
  assign wr_en    = push_vld && (!full || rd_en);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/calc1_port_checker.sv
// Per-port calc1 response checker: predicts each request, queues it, checks responses 1 cycle after out_resp.
// No backpressure: predictions pushed into a full queue are dropped and flagged in sticky q_overflow.
module calc1_port_checker #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic [0:3]       req_cmd_in,
  input  logic [0:31]      req_data_in,
  input  logic [0:1]       out_resp,
  input  logic [0:31]      out_data,
  output logic             chk_pass,
  output logic             chk_fail,
  output logic             chk_timeout,
  output logic [0:1]       err_code,
  output logic [0:31]      exp_data,
  output logic             q_overflow,
  output logic             busy,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] timeout_count
);
  import calc1_pkg::*;

  typedef enum logic {IDLE, OPND2} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t      state;
  logic [0:3]  cmd_q;
  logic [0:31] op1_q;
  logic [TW-1:0] tmo_cnt;
  pred_t       push_dat;
  pred_t       head_dat;
  logic        push_vld, pop_rdy, q_full, q_empty, resp_vld, tmo_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A response in the expiry cycle wins over the timeout.
  assign resp_vld = (out_resp != RESP_NONE);
  assign tmo_hit  = !q_empty && !resp_vld && (tmo_cnt == TW'(TIMEOUT - 1));
  assign pop_rdy  = !q_empty && (resp_vld || tmo_hit);
  assign push_vld = (state == OPND2);
  assign push_dat = predict(cmd_q, op1_q, req_data_in);
  assign busy     = !q_empty || (state == OPND2);

  calc1_chk_fifo #(.DEPTH(DEPTH), .W($bits(pred_t))) u_fifo (
    .clk      (c_clk),
    .rst_n    (reset),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (pop_rdy),
    .head_dat (head_dat),
    .full     (q_full),
    .empty    (q_empty)
  );

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cmd_q         <= '0;
      op1_q         <= '0;
      tmo_cnt       <= '0;
      chk_pass      <= 1'b0;
      chk_fail      <= 1'b0;
      chk_timeout   <= 1'b0;
      err_code      <= ERR_NONE;
      exp_data      <= '0;
      q_overflow    <= 1'b0;
      pass_count    <= '0;
      fail_count    <= '0;
      timeout_count <= '0;
    end else begin
      chk_pass    <= 1'b0;
      chk_fail    <= 1'b0;
      chk_timeout <= 1'b0;
      err_code    <= ERR_NONE;

      case (state)
        IDLE: if (req_cmd_in != CMD_NOP) begin
          cmd_q <= req_cmd_in;
          op1_q <= req_data_in;
          state <= OPND2;
        end
        default: state <= IDLE;
      endcase

      if (push_vld && q_full && !pop_rdy) q_overflow <= 1'b1;

      if (resp_vld) begin
        if (q_empty) begin
          chk_fail   <= 1'b1;
          err_code   <= ERR_UNEXP;
          fail_count <= sat_inc(fail_count);
        end else begin
          exp_data <= head_dat.data;
          if (out_resp != head_dat.resp) begin
            chk_fail   <= 1'b1;
            err_code   <= ERR_RESP;
            fail_count <= sat_inc(fail_count);
          end else if (head_dat.resp == RESP_OK && out_data != head_dat.data) begin
            chk_fail   <= 1'b1;
            err_code   <= ERR_DATA;
            fail_count <= sat_inc(fail_count);
          end else begin
            chk_pass   <= 1'b1;
            pass_count <= sat_inc(pass_count);
          end
        end
      end else if (tmo_hit) begin
        chk_timeout   <= 1'b1;
        exp_data      <= head_dat.data;
        timeout_count <= sat_inc(timeout_count);
      end

      // Counter measures the age of the current head; restarts whenever the head changes.
      tmo_cnt <= (q_empty || pop_rdy) ? '0 : tmo_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_calc1_port_checker.sv
// Scoreboard bench for calc1_port_checker: model predictions queued on stimulus, outcomes checked on pulses.
module tb_calc1_port_checker;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_cmd_in = '0;
  logic [31:0] req_data_in = '0;
  logic [1:0]  out_resp = '0;
  logic [31:0] out_data = '0;
  logic        chk_pass, chk_fail, chk_timeout, q_overflow, busy;
  logic [1:0]  err_code;
  logic [31:0] exp_data;
  logic [15:0] pass_count, fail_count, timeout_count;

  calc1_port_checker #(.DEPTH(4), .TIMEOUT(16), .CNT_W(16)) dut (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
    .out_resp(out_resp), .out_data(out_data), .chk_pass(chk_pass), .chk_fail(chk_fail),
    .chk_timeout(chk_timeout), .err_code(err_code), .exp_data(exp_data),
    .q_overflow(q_overflow), .busy(busy), .pass_count(pass_count),
    .fail_count(fail_count), .timeout_count(timeout_count)
  );

  always #5 c_clk = ~c_clk;

  typedef struct { bit [1:0] resp; bit [31:0] data; } pred_s;
  typedef struct { bit [2:0] flags; bit [1:0] err; bit [31:0] data; } outc_s;  // flags = {pass,fail,tmo}

  pred_s mq[$];
  outc_s sb[$];
  int vectors = 0, miscompares = 0;
  int n_pass = 0, n_fail = 0, n_tmo = 0;
  bit model_ovf = 0;

  function automatic pred_s model_pred(input bit [3:0] cmd, input bit [31:0] a, input bit [31:0] b);
    pred_s p;
    bit [63:0] wide;
    p.resp = 2'd3; p.data = 32'h0;
    case (cmd)
      4'd1: begin wide = 64'(a) + 64'(b); p.data = wide[31:0]; p.resp = (wide > 64'hFFFF_FFFF) ? 2'd2 : 2'd1; end
      4'd2: begin p.data = a - b; p.resp = (a < b) ? 2'd2 : 2'd1; end
      4'd5: begin p.data = a << b[4:0]; p.resp = 2'd1; end
      4'd6: begin p.data = a >> b[4:0]; p.resp = 2'd1; end
      default: ;
    endcase
    return p;
  endfunction

  // Called at posedge+1 with the capture FSM idle; returns at posedge+1 right after the push edge.
  task automatic do_op(input bit [3:0] cmd, input bit [31:0] a, input bit [31:0] b);
    req_cmd_in = cmd; req_data_in = a;
    @(posedge c_clk); #1;
    req_cmd_in = 4'd0; req_data_in = b;
    if (mq.size() < 4) mq.push_back(model_pred(cmd, a, b)); else model_ovf = 1;
    @(posedge c_clk); #1;
    req_data_in = '0;
  endtask

  task automatic expect_resp(input bit [1:0] r, input bit [31:0] d);
    outc_s o;
    pred_s p;
    o.err = 2'd0; o.data = 32'h0;
    if (mq.size() == 0) begin
      o.flags = 3'b010; o.err = 2'd3;
    end else begin
      p = mq.pop_front();
      o.data = p.data;
      if (p.resp != r) begin o.flags = 3'b010; o.err = 2'd1; end
      else if (p.resp == 2'd1 && p.data != d) begin o.flags = 3'b010; o.err = 2'd2; end
      else o.flags = 3'b100;
    end
    if (o.flags[2]) n_pass++; else n_fail++;
    sb.push_back(o);
  endtask

  task automatic send_resp(input bit [1:0] r, input bit [31:0] d);
    expect_resp(r, d);
    out_resp = r; out_data = d;
    @(posedge c_clk); #1;
    out_resp = '0; out_data = '0;
  endtask

  task automatic wait_pulse(input int maxc, output int cyc, output bit got);
    got = 0; cyc = 0;
    while (!got && cyc <= maxc) begin
      if (chk_pass || chk_fail || chk_timeout) got = 1;
      else begin @(posedge c_clk); #1; cyc++; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge c_clk);
    #1;
    vectors++;
    if ({chk_pass, chk_fail, chk_timeout, err_code, exp_data, q_overflow, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got p%b f%b t%b e%0d d%h ov%b busy%b, want all 0",
               chk_pass, chk_fail, chk_timeout, err_code, exp_data, q_overflow, busy);
    end
    vectors++;
    if ({pass_count, fail_count, timeout_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_counts: got %0d/%0d/%0d, want 0/0/0", pass_count, fail_count, timeout_count);
    end
    @(negedge c_clk) reset = 1'b1;
    @(posedge c_clk); #1;
  endtask

  task automatic test_add_pass;
    int cyc; bit got; outc_s o;
    do_op(4'd1, 32'hFFFF0000, 32'h0000FFFF);
    repeat (3) begin @(posedge c_clk); #1; end
    send_resp(2'd1, 32'hFFFFFFFF);
    wait_pulse(5, cyc, got); o = sb.pop_front(); vectors++;
    if (!got || {chk_pass, chk_fail, chk_timeout} !== o.flags || exp_data !== o.data) begin
      miscompares++;
      $display("FAIL add_pass: got pulses=%b data=%h, want pulses=%b data=%h",
               {chk_pass, chk_fail, chk_timeout}, exp_data, o.flags, o.data);
    end
    vectors++;
    if (pass_count !== 16'(n_pass)) begin
      miscompares++; $display("FAIL add_pass_count: got %0d want %0d", pass_count, n_pass);
    end
  endtask

  task automatic test_fail_codes;
    int cyc; bit got; outc_s o;
    do_op(4'd1, 32'h80000000, 32'h80000000);
    send_resp(2'd1, 32'h00000000);
    wait_pulse(5, cyc, got); o = sb.pop_front(); vectors++;
    if (!got || {chk_pass, chk_fail, chk_timeout} !== o.flags || err_code !== o.err) begin
      miscompares++;
      $display("FAIL add_ovf_resp: got pulses=%b err=%0d, want pulses=%b err=%0d",
               {chk_pass, chk_fail, chk_timeout}, err_code, o.flags, o.err);
    end
    do_op(4'd5, 32'h00000001, 32'h00000024);
    send_resp(2'd1, 32'h00000020);
    wait_pulse(5, cyc, got); o = sb.pop_front(); vectors++;
    if (!got || {chk_pass, chk_fail, chk_timeout} !== o.flags || err_code !== o.err || exp_data !== o.data) begin
      miscompares++;
      $display("FAIL lsh_data: got pulses=%b err=%0d data=%h, want pulses=%b err=%0d data=%h",
               {chk_pass, chk_fail, chk_timeout}, err_code, exp_data, o.flags, o.err, o.data);
    end
    send_resp(2'd1, 32'h12345678);
    wait_pulse(5, cyc, got); o = sb.pop_front(); vectors++;
    if (!got || {chk_pass, chk_fail, chk_timeout} !== o.flags || err_code !== o.err) begin
      miscompares++;
      $display("FAIL unexpected_resp: got pulses=%b err=%0d, want pulses=%b err=%0d",
               {chk_pass, chk_fail, chk_timeout}, err_code, o.flags, o.err);
    end
    vectors++;
    if (fail_count !== 16'(n_fail)) begin
      miscompares++; $display("FAIL fail_count: got %0d want %0d", fail_count, n_fail);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; bit got; outc_s o; pred_s p;
    do_op(4'd6, 32'hF0000000, 32'hFFFFFFE8);
    // Response for the RSH lands on the same edge that pushes the SUB.
    req_cmd_in = 4'd2; req_data_in = 32'h00000009;
    @(posedge c_clk); #1;
    req_cmd_in = 4'd0; req_data_in = 32'h00000004;
    expect_resp(2'd1, 32'h000000F0);
    out_resp = 2'd1; out_data = 32'h000000F0;
    p = model_pred(4'd2, 32'h9, 32'h4);
    mq.push_back(p);
    @(posedge c_clk); #1;
    out_resp = '0; out_data = '0; req_data_in = '0;
    wait_pulse(5, cyc, got); o = sb.pop_front(); vectors++;
    if (!got || {chk_pass, chk_fail, chk_timeout} !== o.flags || exp_data !== o.data) begin
      miscompares++;
      $display("FAIL b2b_rsh: got pulses=%b data=%h, want pulses=%b data=%h",
               {chk_pass, chk_fail, chk_timeout}, exp_data, o.flags, o.data);
    end
    send_resp(2'd1, 32'h00000005);
    wait_pulse(5, cyc, got); o = sb.pop_front(); vectors++;
    if (!got || {chk_pass, chk_fail, chk_timeout} !== o.flags || exp_data !== o.data) begin
      miscompares++;
      $display("FAIL b2b_sub: got pulses=%b data=%h, want pulses=%b data=%h",
               {chk_pass, chk_fail, chk_timeout}, exp_data, o.flags, o.data);
    end
    do_op(4'd7, 32'hDEADBEEF, 32'h1);
    send_resp(2'd3, 32'hCAFEF00D);
    wait_pulse(5, cyc, got); o = sb.pop_front(); vectors++;
    if (!got || {chk_pass, chk_fail, chk_timeout} !== o.flags) begin
      miscompares++;
      $display("FAIL invalid_cmd: got pulses=%b, want pulses=%b", {chk_pass, chk_fail, chk_timeout}, o.flags);
    end
  endtask

  task automatic test_timeout;
    int cyc; bit got; outc_s o;
    // Response on the expiry edge must be checked, not timed out.
    do_op(4'd2, 32'h5, 32'h3);
    repeat (15) begin @(posedge c_clk); #1; end
    send_resp(2'd1, 32'h2);
    wait_pulse(5, cyc, got); o = sb.pop_front(); vectors++;
    if (!got || cyc != 0 || {chk_pass, chk_fail, chk_timeout} !== o.flags) begin
      miscompares++;
      $display("FAIL resp_at_limit: got pulses=%b after %0d, want pulses=%b after 0",
               {chk_pass, chk_fail, chk_timeout}, cyc, o.flags);
    end
    do_op(4'd2, 32'h1, 32'h2);
    void'(mq.pop_front());
    n_tmo++;
    wait_pulse(40, cyc, got); vectors++;
    if (!got || cyc != 16 || {chk_pass, chk_fail, chk_timeout} !== 3'b001) begin
      miscompares++;
      $display("FAIL timeout: got pulses=%b after %0d cycles, want 001 after 16",
               {chk_pass, chk_fail, chk_timeout}, cyc);
    end
    vectors++;
    if (busy !== 1'b0 || timeout_count !== 16'(n_tmo)) begin
      miscompares++;
      $display("FAIL timeout_after: got busy=%b tcount=%0d, want busy=0 tcount=%0d", busy, timeout_count, n_tmo);
    end
  endtask

  task automatic test_overflow_reset;
    int cyc; bit got; outc_s o; bit seen;
    for (int i = 0; i < 5; i++) do_op(4'd1, 32'(i), 32'h10);
    vectors++;
    if (q_overflow !== model_ovf || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow: got ovf=%b busy=%b, want ovf=%b busy=1", q_overflow, busy, model_ovf);
    end
    req_cmd_in = 4'd1; req_data_in = 32'h7;
    @(posedge c_clk); #1;
    reset = 1'b0;
    req_cmd_in = 4'd0;
    #1;
    mq.delete(); sb.delete(); n_pass = 0; n_fail = 0; n_tmo = 0; model_ovf = 0;
    vectors++;
    if ({chk_pass, chk_fail, chk_timeout, err_code, exp_data, q_overflow, busy,
         pass_count, fail_count, timeout_count} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got ovf=%b busy=%b data=%h counts=%0d/%0d/%0d, want all 0",
               q_overflow, busy, exp_data, pass_count, fail_count, timeout_count);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge c_clk); #1;
      if (chk_pass || chk_fail || chk_timeout) seen = 1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL reset_pulse: got pulse during reset, want none"); end
    @(negedge c_clk) reset = 1'b1;
    @(posedge c_clk); #1;
    do_op(4'd1, 32'h2, 32'h3);
    send_resp(2'd1, 32'h5);
    wait_pulse(5, cyc, got); o = sb.pop_front(); vectors++;
    if (!got || {chk_pass, chk_fail, chk_timeout} !== o.flags || pass_count !== 16'(n_pass)) begin
      miscompares++;
      $display("FAIL post_reset: got pulses=%b pcount=%0d, want pulses=%b pcount=%0d",
               {chk_pass, chk_fail, chk_timeout}, pass_count, o.flags, n_pass);
    end
  endtask

  initial begin
    test_reset();
    test_add_pass();
    test_fail_codes();
    test_back_to_back();
    test_timeout();
    test_overflow_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
